// File: rtl/tile_map_ctrl_if.sv
// Write port of the tile map: the requester holds wr_req until the store
// answers with a one-cycle wr_ack, with wr_hit qualifying the outcome.
interface tile_map_ctrl_if #(
  parameter int XW     = 5,
  parameter int YW     = 5,
  parameter int TILE_W = 2
);
  logic              wr_req;
  logic [XW-1:0]     wr_x;
  logic [YW-1:0]     wr_y;
  logic [TILE_W-1:0] wr_tile;
  logic              wr_ack;
  logic              wr_hit;

  modport master (output wr_req, wr_x, wr_y, wr_tile, input wr_ack, wr_hit);
  modport slave  (input wr_req, wr_x, wr_y, wr_tile, output wr_ack, wr_hit);
endinterface

// File: rtl/tile_map_ctrl.sv
// Tank playfield tile store: level loader, render/collision read ports,
// bullet-damage/build write port and a live brick count.
//
// state | meaning
// LOAD  | walking the grid one cell per cycle writing the default level
// IDLE  | map live, waiting for a write request
// WACK  | applying the latched write, pulsing wr_ack
module tile_map_ctrl #(
  parameter int MAP_W       = 25,
  parameter int MAP_H       = 18,
  parameter int TILE_W      = 2,
  parameter int XW          = 5,
  parameter int YW          = 5,
  parameter int CW          = 10,
  parameter bit ALLOW_BUILD = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reload,
  output logic              busy,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [TILE_W-1:0] rd_tile,
  input  logic [XW-1:0]     cq_x,
  input  logic [YW-1:0]     cq_y,
  output logic              cq_solid,
  tile_map_ctrl_if.slave    wr,
  output logic [CW-1:0]     brick_cnt
);

  typedef enum logic [1:0] {LOAD, IDLE, WACK} state_e;

  localparam logic [XW-1:0]     X_LAST = XW'(MAP_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(MAP_H - 1);
  localparam logic [TILE_W-1:0] T_EMPTY = '0;
  localparam logic [TILE_W-1:0] T_BRICK = TILE_W'(1);
  localparam logic [TILE_W-1:0] T_STEEL = TILE_W'(2);

  state_e            state_q;
  logic [XW-1:0]     cx_q;
  logic [YW-1:0]     cy_q;
  logic [TILE_W-1:0] map_q [MAP_H][MAP_W];
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic [TILE_W-1:0] rd_tile_q;
  logic              cq_solid_q;
  logic              ack_q;
  logic              hit_q;
  logic [XW-1:0]     lx_q;
  logic [YW-1:0]     ly_q;
  logic [TILE_W-1:0] lt_q;

  logic              rd_in, cq_in, lw_in;
  logic [TILE_W-1:0] rd_cell_d, cq_cell_d, lw_cell_d, load_tile_d;

  function automatic logic [TILE_W-1:0] layout(input logic [XW-1:0] x, input logic [YW-1:0] y);
    if (x == '0 || y == '0 || x == X_LAST || y == Y_LAST) return T_STEEL;
    if (x[1:0] == 2'b00 && y[1:0] == 2'b10) return T_BRICK;
    return T_EMPTY;
  endfunction

  assign rd_in = (int'(rd_x) < MAP_W) && (int'(rd_y) < MAP_H);
  assign cq_in = (int'(cq_x) < MAP_W) && (int'(cq_y) < MAP_H);
  assign lw_in = (int'(lx_q) < MAP_W) && (int'(ly_q) < MAP_H);

  assign rd_cell_d   = rd_in ? map_q[rd_y][rd_x] : T_EMPTY;
  assign cq_cell_d   = cq_in ? map_q[cq_y][cq_x] : T_EMPTY;
  assign lw_cell_d   = lw_in ? map_q[ly_q][lx_q] : T_EMPTY;
  assign load_tile_d = layout(cx_q, cy_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= LOAD;
      cx_q       <= '0;
      cy_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      rd_tile_q  <= '0;
      cq_solid_q <= 1'b1;
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      lx_q       <= '0;
      ly_q       <= '0;
      lt_q       <= '0;
      for (int y = 0; y < MAP_H; y++)
        for (int x = 0; x < MAP_W; x++)
          map_q[y][x] <= T_EMPTY;
    end else begin
      // Reads sample the array before any write of this cycle lands.
      rd_tile_q  <= rd_cell_d;
      cq_solid_q <= !cq_in || (cq_cell_d != T_EMPTY);
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;

      if (reload) begin
        state_q <= LOAD;
        cx_q    <= '0;
        cy_q    <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        for (int y = 0; y < MAP_H; y++)
          for (int x = 0; x < MAP_W; x++)
            map_q[y][x] <= T_EMPTY;
      end else begin
        case (state_q)
          LOAD: begin
            map_q[cy_q][cx_q] <= load_tile_d;
            if (load_tile_d == T_BRICK && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (cx_q == X_LAST) begin
              cx_q <= '0;
              if (cy_q == Y_LAST) begin
                cy_q    <= '0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                cy_q <= cy_q + 1'b1;
              end
            end else begin
              cx_q <= cx_q + 1'b1;
            end
          end
          IDLE: begin
            // A request still high during its own ack cycle is the old one.
            if (wr.wr_req && !ack_q) begin
              lx_q    <= wr.wr_x;
              ly_q    <= wr.wr_y;
              lt_q    <= wr.wr_tile;
              state_q <= WACK;
            end
          end
          WACK: begin
            ack_q   <= 1'b1;
            state_q <= IDLE;
            if (lw_in) begin
              if (lw_cell_d == T_BRICK && lt_q != T_BRICK) begin
                map_q[ly_q][lx_q] <= lt_q;
                hit_q             <= 1'b1;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
              end else if (lw_cell_d == T_EMPTY && ALLOW_BUILD && lt_q == T_BRICK) begin
                map_q[ly_q][lx_q] <= T_BRICK;
                hit_q             <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign rd_tile   = rd_tile_q;
  assign cq_solid  = cq_solid_q;
  assign brick_cnt = cnt_q;
  assign wr.wr_ack = ack_q;
  assign wr.wr_hit = hit_q;

endmodule
